// File: rtl/pmem_responder.sv
// pmem_responder: line-organised memory answering pmem read/write requests after a
// fixed latency, with a sticky protocol-violation flag and transaction counters.
module pmem_responder #(
  parameter int LATENCY = 4,
  parameter int LINES   = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [255:0] pmem_rdata,
  output logic         proto_err,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
);

  localparam int         IDX_W        = $clog2(LINES);
  localparam logic [3:0] WAIT_INIT    = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit         SINGLE_CYCLE = (LATENCY == 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t             state_r;
  logic [3:0]         wait_cnt_r;
  logic               op_write_r;
  logic [IDX_W-1:0]   idx_r;
  logic [255:0]       wdata_r;
  logic [255:0]       mem_r [LINES];

  logic [IDX_W-1:0]   addr_idx_s;
  logic               req_held_s;
  logic               conflict_s;
  logic               accept_s;
  logic               unused_addr_s;

  // Request decode: line index from the address and the latched op's request line.
  always_comb begin
    addr_idx_s = pmem_address[5 +: IDX_W];
    req_held_s = op_write_r ? pmem_write : pmem_read;
    conflict_s = pmem_read & pmem_write;
    accept_s   = pmem_read ^ pmem_write;
  end

  // Offset bits and aliased upper bits carry no meaning for this memory.
  assign unused_addr_s = ^{pmem_address[4:0], pmem_address[31:5+IDX_W]};

  // Line storage: not reset, and written only on the edge that ends RESP.
  always_ff @(posedge clk) begin
    if (state_r == ST_RESP && op_write_r) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  // Transaction FSM with registered response, read data, error flag and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      op_write_r <= 1'b0;
      idx_r      <= '0;
      wdata_r    <= 256'd0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= 256'd0;
      proto_err  <= 1'b0;
      rd_count   <= 32'd0;
      wr_count   <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pmem_resp <= 1'b0;
          if (conflict_s) begin
            proto_err <= 1'b1;
          end else if (accept_s) begin
            op_write_r <= pmem_write;
            idx_r      <= addr_idx_s;
            wdata_r    <= pmem_wdata;
            wait_cnt_r <= WAIT_INIT;
            if (SINGLE_CYCLE) begin
              state_r   <= ST_RESP;
              pmem_resp <= 1'b1;
              if (pmem_read) begin
                pmem_rdata <= mem_r[addr_idx_s];
              end
            end else begin
              state_r <= ST_WAIT;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // A dropped request is treated as an abort, checked before completion.
          if (!req_held_s) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            proto_err  <= 1'b1;
          end else if (wait_cnt_r == 4'd0) begin
            state_r   <= ST_RESP;
            pmem_resp <= 1'b1;
            if (!op_write_r) begin
              pmem_rdata <= mem_r[idx_r];
            end
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          pmem_resp <= 1'b0;
          state_r   <= ST_GAP;
          if (op_write_r) begin
            wr_count <= wr_count + 32'd1;
          end else begin
            rd_count <= rd_count + 32'd1;
          end
        end
        ST_GAP: begin
          pmem_resp <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          pmem_resp <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: two instances (LATENCY 4 / LINES 64, LATENCY 1 / LINES 16)
// driven by transaction tasks that schedule the expected outputs cycle by cycle.
module tb_pmem_responder;

  localparam int LAT0 = 4;
  localparam int LINES0 = 64;
  localparam int LAT1 = 1;
  localparam int LINES1 = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         rd [2];
  logic         wr [2];
  logic [31:0]  addr [2];
  logic [255:0] wdata [2];

  logic         resp0, resp1, err0, err1;
  logic [255:0] rdata0, rdata1;
  logic [31:0]  rdc0, rdc1, wrc0, wrc1;

  logic         act_resp [2];
  logic [255:0] act_rdata [2];
  logic         act_err [2];
  logic [31:0]  act_rdc [2];
  logic [31:0]  act_wrc [2];

  pmem_responder #(.LATENCY(LAT0), .LINES(LINES0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wdata[0]), .pmem_resp(resp0),
    .pmem_rdata(rdata0), .proto_err(err0), .rd_count(rdc0), .wr_count(wrc0)
  );

  pmem_responder #(.LATENCY(LAT1), .LINES(LINES1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wdata[1]), .pmem_resp(resp1),
    .pmem_rdata(rdata1), .proto_err(err1), .rd_count(rdc1), .wr_count(wrc1)
  );

  always_comb begin
    act_resp[0] = resp0;   act_resp[1] = resp1;
    act_rdata[0] = rdata0; act_rdata[1] = rdata1;
    act_err[0] = err0;     act_err[1] = err1;
    act_rdc[0] = rdc0;     act_rdc[1] = rdc1;
    act_wrc[0] = wrc0;     act_wrc[1] = wrc1;
  end

  // Reference model state
  logic         exp_resp [2];
  logic [255:0] exp_rdata [2];
  bit           rknown [2];
  logic         exp_err [2];
  logic [31:0]  exp_rd [2];
  logic [31:0]  exp_wr [2];
  logic [255:0] mmem [2][64];
  bit           mknown [2][64];

  int cyc = 0;
  int last_resp_cyc [2] = '{-1, -1};
  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int lines_of(input int i);
    return (i == 0) ? LINES0 : LINES1;
  endfunction

  function automatic int line_of(input int i, input logic [31:0] a);
    return int'((a >> 5) & 32'(lines_of(i) - 1));
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input int i, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, i, cyc, act, exp);
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (act_resp[i] === 1'b1) last_resp_cyc[i] = cyc;
      if (chk_on) begin
        chk("resp", i, 256'(act_resp[i]), 256'(exp_resp[i]));
        if (rknown[i]) chk("rdata", i, act_rdata[i], exp_rdata[i]);
        chk("proto_err", i, 256'(act_err[i]), 256'(exp_err[i]));
        chk("rd_count", i, 256'(act_rdc[i]), 256'(exp_rd[i]));
        chk("wr_count", i, 256'(act_wrc[i]), 256'(exp_wr[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0;
      exp_resp[i] = 1'b0; exp_rdata[i] = 256'd0; rknown[i] = 1'b1;
      exp_err[i] = 1'b0; exp_rd[i] = 32'd0; exp_wr[i] = 32'd0;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    chk_on = 1'b1;
    reset_model();
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  // Complete transaction starting in an IDLE cycle: response LAT cycles after the
  // request first appears, counters/memory updated the cycle after, then one GAP.
  task automatic do_txn(input int i, input bit is_wr, input logic [31:0] a,
                        input logic [255:0] d, input bit hold_gap);
    int L;
    int idx;
    L = lat_of(i);
    idx = line_of(i, a);
    for (int c = 0; c <= L + 1; c++) begin
      if (c == 0) begin
        rd[i] = !is_wr; wr[i] = is_wr; addr[i] = a; wdata[i] = d;
      end else begin
        addr[i] = $urandom; wdata[i] = rand256();
      end
      exp_resp[i] = (c == L);
      if (c == L && !is_wr) begin
        exp_rdata[i] = mmem[i][idx];
        rknown[i] = mknown[i][idx];
      end
      if (c == L + 1) begin
        if (!hold_gap) begin rd[i] = 1'b0; wr[i] = 1'b0; end
        if (is_wr) begin
          mmem[i][idx] = d; mknown[i][idx] = 1'b1; exp_wr[i] = exp_wr[i] + 32'd1;
        end else begin
          exp_rd[i] = exp_rd[i] + 32'd1;
        end
      end
      tick();
    end
    rd[i] = 1'b0; wr[i] = 1'b0;
  endtask

  // Request dropped in cycle dc (1..L-1) while waiting: error, nothing else changes.
  task automatic do_abort(input int i, input bit is_wr, input logic [31:0] a,
                          input logic [255:0] d, input int dc);
    for (int c = 0; c <= dc; c++) begin
      if (c == 0) begin
        rd[i] = !is_wr; wr[i] = is_wr; addr[i] = a; wdata[i] = d;
      end else begin
        addr[i] = $urandom; wdata[i] = rand256();
      end
      if (c == dc) begin rd[i] = 1'b0; wr[i] = 1'b0; end
      exp_resp[i] = 1'b0;
      tick();
    end
    exp_err[i] = 1'b1;
  endtask

  task automatic do_conflict(input int i, input logic [31:0] a, input logic [255:0] d);
    rd[i] = 1'b1; wr[i] = 1'b1; addr[i] = a; wdata[i] = d;
    tick();
    rd[i] = 1'b0; wr[i] = 1'b0;
    exp_err[i] = 1'b1;
  endtask

  task automatic rand_txn(input int i);
    int r;
    logic [31:0] a;
    logic [255:0] d;
    r = $urandom_range(0, 19);
    a = $urandom;
    d = rand256();
    if (r < 8) do_txn(i, 1'b1, a, d, 1'($urandom_range(0, 1)));
    else if (r < 17) do_txn(i, 1'b0, a, d, 1'($urandom_range(0, 1)));
    else if (r < 19 && lat_of(i) > 1)
      do_abort(i, 1'($urandom_range(0, 1)), a, d, $urandom_range(1, lat_of(i) - 1));
    else do_conflict(i, a, d);
  endtask

  task automatic init_mem(input int i);
    for (int l = 0; l < lines_of(i); l++)
      do_txn(i, 1'b1, ($urandom & ~32'((lines_of(i) - 1) << 5)) | 32'(l << 5), rand256(), 1'b0);
  endtask

  // Read held through GAP and into IDLE on the LATENCY-4 instance: the IDLE cycle
  // starts a fresh request which the later drop aborts, so only one pulse appears.
  task automatic held2(input logic [31:0] a);
    int idx;
    idx = line_of(0, a);
    for (int c = 0; c <= LAT0 + 3; c++) begin
      if (c == 0) begin rd[0] = 1'b1; wr[0] = 1'b0; addr[0] = a; end
      else addr[0] = $urandom;
      exp_resp[0] = (c == LAT0);
      if (c == LAT0) begin exp_rdata[0] = mmem[0][idx]; rknown[0] = mknown[0][idx]; end
      if (c == LAT0 + 1) exp_rd[0] = exp_rd[0] + 32'd1;
      if (c == LAT0 + 3) rd[0] = 1'b0;
      tick();
    end
    exp_err[0] = 1'b1;
  endtask

  localparam logic [255:0] BEEF = {8{32'hDEADBEEF}};
  localparam logic [255:0] L3V  = {8{32'h12345678}};

  initial begin
    int s;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 256'd0;
    end
    tick();
    do_reset(2);
    chk("reset_rdata", 0, rdata0, 256'd0);
    chk("reset_rdc", 0, 256'(rdc0), 256'd0);
    chk("reset_err", 0, 256'(err0), 256'd0);

    // write then read with 4-cycle latency
    s = cyc;
    do_txn(0, 1'b1, 32'h0000_0040, BEEF, 1'b0);
    chk("lat4_resp_offset", 0, 256'(last_resp_cyc[0] - s), 256'd4);
    do_txn(0, 1'b0, 32'h0000_0040, 256'd0, 1'b0);
    chk("wr_rd_data", 0, rdata0, BEEF);
    chk("wr_rd_wrc", 0, 256'(wrc0), 256'd1);
    chk("wr_rd_rdc", 0, 256'(rdc0), 256'd1);

    // single-cycle latency instance
    s = cyc;
    do_txn(1, 1'b1, 32'h0000_0020, 256'hA5, 1'b0);
    chk("lat1_resp_offset", 1, 256'(last_resp_cyc[1] - s), 256'd1);

    // aliasing
    do_txn(0, 1'b1, 32'h0000_0820, 256'h1, 1'b0);
    do_txn(0, 1'b0, 32'h0000_0020, 256'd0, 1'b0);
    chk("alias_rd", 0, rdata0, 256'h1);
    do_txn(0, 1'b0, 32'h0000_003F, 256'd0, 1'b0);
    chk("alias_offset_rd", 0, rdata0, 256'h1);

    fork
      init_mem(0);
      init_mem(1);
    join
    fork
      repeat (150) rand_txn(0);
      repeat (300) rand_txn(1);
    join

    // conflict leaves memory untouched
    do_txn(0, 1'b1, 32'h0000_0060, L3V, 1'b0);
    do_conflict(0, 32'h0000_0060, 256'hBAD);
    chk("conflict_err", 0, 256'(err0), 256'd1);
    do_txn(0, 1'b0, 32'h0000_0060, 256'd0, 1'b0);
    chk("conflict_mem", 0, rdata0, L3V);

    // abort accepted in the very first cycle after reset release
    do_reset(2);
    do_abort(0, 1'b0, 32'h0000_0080, 256'd0, 2);
    chk("abort_err", 0, 256'(err0), 256'd1);
    chk("abort_rdc", 0, 256'(rdc0), 256'd0);
    do_txn(0, 1'b0, 32'h0000_0060, 256'd0, 1'b0);
    chk("after_abort_rd", 0, rdata0, L3V);

    // reset in the middle of a write to line 3
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h0000_0060; wdata[0] = 256'hF;
    tick();
    addr[0] = $urandom; wdata[0] = rand256();
    tick();
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("midrst_resp", 0, 256'(resp0), 256'd0);
    chk("midrst_rdata", 0, rdata0, 256'd0);
    chk("midrst_rdc", 0, 256'(rdc0), 256'd0);
    chk("midrst_wrc", 0, 256'(wrc0), 256'd0);
    chk("midrst_err", 0, 256'(err0), 256'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    do_txn(0, 1'b0, 32'h0000_0060, 256'd0, 1'b0);
    chk("midrst_line3", 0, rdata0, L3V);

    // held request
    do_reset(1);
    held2(32'h0000_0060);
    chk("held_rdc", 0, 256'(rdc0), 256'd1);
    chk("held_rdata", 0, rdata0, L3V);
    do_txn(1, 1'b0, 32'h0000_0020, 256'd0, 1'b1);
    chk("held_gap_rdc", 1, 256'(rdc1), 256'd1);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
